// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder sequencer that drives one
// external full-adder cell, LSB first, one bit per clock.
//
// Ports:
//   clk, rst         clock, async active-high reset
//   start            request pulse, accepted only in IDLE
//   a, b, cin        operands, latched on the accepting edge
//   sub              (SERIAL_ADD_SUB_EN only) 1 = compute a - b
//   busy             high while bits are being processed
//   done             one-cycle pulse, sum/cout valid
//   sum, cout        result, held until the next accepted start
//   fa_a/fa_b/fa_cin outputs to the external FA cell
//   fa_sum/fa_cout   inputs from the external FA cell
//
// Optional feature macro: SERIAL_ADD_SUB_EN (adds the sub port).
module serial_add_ctrl #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  // Operand B and initial carry as loaded on an accepted start.
  // Subtraction is a + ~b + 1, so the carry-in is forced high.
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;

`ifdef SERIAL_ADD_SUB_EN
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub | cin;
`else
  assign b_ld = b;
  assign c_ld = cin;
`endif

  // The incoming FA sum bit enters at the MSB, so after WIDTH
  // shifts bit 0 of the result sits in sum_sh[0].
  logic [WIDTH-1:0] sum_nx;
  assign sum_nx = {fa_sum, sum_sh[WIDTH-1:1]};

  // busy is a register that is set exactly while in RUN, so it
  // doubles as the gate keeping the FA inputs quiet elsewhere.
  assign fa_a   = busy & a_sh[0];
  assign fa_b   = busy & b_sh[0];
  assign fa_cin = busy & carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b_ld;
            carry <= c_ld;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum_sh <= sum_nx;
          carry  <= fa_cout;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + ONE;
          if (cnt == LAST) begin
            sum   <= sum_nx;
            cout  <= fa_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // start is ignored here; the requester sees done first.
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: self-checking bench for serial_add_ctrl.
// Includes a behavioural full-adder cell and arithmetic model.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         fa_a;
  logic         fa_b;
  logic         fa_cin;
  logic         fa_sum;
  logic         fa_cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External single-bit full adder.
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .cin     (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub     (sub),
`endif
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .fa_a    (fa_a),
    .fa_b    (fa_b),
    .fa_cin  (fa_cin),
    .fa_sum  (fa_sum),
    .fa_cout (fa_cout)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: {cout,sum} = a + b + cin (or a - b as a + ~b + 1).
  function automatic logic [W:0] ref_add(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic c,
                                         input logic s);
    logic [W:0] r;
    r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
`ifdef SERIAL_ADD_SUB_EN
    if (s)
      r = {1'b0, x} + {1'b0, ~y} + 1;
`else
    if (s)
      r = r;
`endif
    return r;
  endfunction

  // One transaction; inj >= 0 raises a stray start (a=b=1) for one
  // cycle at that many edges into RUN.
  task automatic do_add(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic is, input int inj,
                        output logic [W-1:0] rs, output logic rc,
                        output int lat, output int bcnt,
                        output logic [W-1:0] fab);
    int w;
    w = 0;
    @(negedge clk);
    while ((busy || done) && w < 30) begin
      @(negedge clk);
      w++;
    end
    if (w >= 30)
      chk("idle_wait", {31'd0, busy | done}, 0);
    a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = 0; bcnt = 0; fab = '0;
    while (!done && lat < 40) begin
      if (busy) begin
        bcnt++;
        if (lat < W) fab[lat] = fa_a;
      end
      if (lat == inj) begin
        a = 8'h01; b = 8'h01; start = 1'b1;
      end
      if (lat == inj + 1) start = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    rs = sum;
    rc = cout;
    chk("busy_with_done", {31'd0, busy}, 0);
    chk("fa_quiet", {29'd0, fa_a, fa_b, fa_cin}, 0);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [W-1:0] rs;
    logic         rc;
    logic [W-1:0] fab;
    logic [W:0]   exp;
    int           lat;
    int           bcnt;
    int           last_done;
    int           ndone;
    int           cyc;
    logic         prev_done;
    logic         rsub;

    vt[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[1] = '{8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0};
    vt[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vt[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vt[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_sum", {24'd0, sum}, 0);
    chk("rst_cout", {31'd0, cout}, 0);
    chk("rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table (covers tests 1 and 2).
    for (int i = 0; i < 6; i++) begin
      do_add(vt[i].a, vt[i].b, vt[i].c, 1'b0, -1, rs, rc, lat, bcnt, fab);
      chk($sformatf("vec%0d_sum", i), {24'd0, rs}, {24'd0, vt[i].s});
      chk($sformatf("vec%0d_cout", i), {31'd0, rc}, {31'd0, vt[i].co});
      chk($sformatf("vec%0d_lat", i), lat, W);
      chk($sformatf("vec%0d_busy", i), bcnt, W);
      chk($sformatf("vec%0d_fa_a", i), {24'd0, fab}, {24'd0, vt[i].a});
    end

    // Stray start during RUN is dropped; a later start runs normally.
    do_add(8'h5A, 8'h33, 1'b1, 1'b0, 3, rs, rc, lat, bcnt, fab);
    chk("ign_sum", {24'd0, rs}, 32'h8E);
    chk("ign_cout", {31'd0, rc}, 0);
    chk("ign_lat", lat, W);
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("ign_no_rerun", {30'd0, busy, done}, 0);
    end
    do_add(8'h01, 8'h01, 1'b0, 1'b0, -1, rs, rc, lat, bcnt, fab);
    chk("after_sum", {24'd0, rs}, 32'h02);

    // Async reset during the 4th RUN cycle.
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_done", {31'd0, done}, 0);
    chk("arst_sum", {24'd0, sum}, 0);
    chk("arst_cout", {31'd0, cout}, 0);
    chk("arst_fa", {29'd0, fa_a, fa_b, fa_cin}, 0);
    @(negedge clk);
    rst = 1'b0;
    do_add(8'h12, 8'h34, 1'b0, 1'b0, -1, rs, rc, lat, bcnt, fab);
    chk("post_rst_sum", {24'd0, rs}, 32'h46);
    chk("post_rst_lat", lat, W);

    // start held high: one add every W+2 cycles.
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0; start = 1'b1;
    last_done = -1; ndone = 0; prev_done = 1'b0;
    for (cyc = 0; cyc < 45; cyc++) begin
      @(posedge clk);
      #1;
      if (busy && done) chk("b2b_overlap", 1, 0);
      if (done) begin
        if (prev_done) chk("b2b_wide_done", 1, 0);
        chk("b2b_sum", {24'd0, sum}, 32'h30);
        if (last_done >= 0)
          chk("b2b_period", cyc - last_done, W + 2);
        last_done = cyc;
        ndone++;
      end
      prev_done = done;
    end
    start = 1'b0;
    chk("b2b_count_ok", {31'd0, ndone >= 4}, 1);

`ifdef SERIAL_ADD_SUB_EN
    do_add(8'h05, 8'h07, 1'b0, 1'b1, -1, rs, rc, lat, bcnt, fab);
    chk("sub1_sum", {24'd0, rs}, 32'hFE);
    chk("sub1_cout", {31'd0, rc}, 0);
    do_add(8'h07, 8'h05, 1'b1, 1'b1, -1, rs, rc, lat, bcnt, fab);
    chk("sub2_sum", {24'd0, rs}, 32'h02);
    chk("sub2_cout", {31'd0, rc}, 1);
`endif

    // Randomised adds against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rcin;
      ra = W'($urandom);
      rb = W'($urandom);
      rcin = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rsub = 1'($urandom);
`else
      rsub = 1'b0;
`endif
      exp = ref_add(ra, rb, rcin, rsub);
      do_add(ra, rb, rcin, rsub, -1, rs, rc, lat, bcnt, fab);
      chk($sformatf("rnd%0d_res", i), {23'd0, rc, rs}, {23'd0, exp});
      chk($sformatf("rnd%0d_lat", i), lat, W);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
